// File: rtl/vram_bus_sched.sv
// PPU VRAM bus scheduler: two-cycle ALE/data transactions shared between render fetches and the CPU $2007 port.
// Optional starvation guard for CPU requests is enabled by defining VRAM_SCHED_STARVE_GUARD_EN.
module vram_bus_sched #(
    parameter int AW           = 14,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          BLNK,
    input  logic          REN_REQ,
    input  logic [AW-1:0] REN_ADDR,
    output logic          REN_ACK,
    output logic [DW-1:0] REN_DATA,
    output logic          REN_VLD,
    input  logic          CPU_RD,
    input  logic          CPU_WR,
    input  logic [DW-1:0] CPU_WDATA,
    input  logic [AW-1:0] CPU_ADDR,
    output logic          CPU_BUSY,
    output logic          CPU_OVF,
    input  logic [DW-1:0] PD_IN,
    output logic [AW-1:0] PA_OUT,
    output logic [DW-1:0] PD_OUT,
    output logic          PD_OE,
    output logic          ALE,
    output logic          RD,
    output logic          WR,
    output logic [DW-1:0] RB_DATA,
    output logic          RB_LOAD,
    output logic          TSTEP
);

    typedef enum logic [2:0] {IDLE, R_ALE, R_DAT, C_ALE, C_DAT} state_t;

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic          pendWr_q, pendWr_d;
    logic [DW-1:0] pendData_q, pendData_d;
    logic          curWr_q, curWr_d;
    logic [DW-1:0] curData_q, curData_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          renVld_q, renVld_d;
    logic [DW-1:0] renData_q, renData_d;
    logic          rbLoad_q, rbLoad_d;
    logic [DW-1:0] rbData_q, rbData_d;

    logic          cpuPulse, effPend, effWr, renGo, decide, grant, starveHit;
    logic [DW-1:0] effData;

    // A pulse in the current cycle counts as pending so a free bus grants it on the next edge.
    assign cpuPulse = CPU_RD | CPU_WR;
    assign effPend  = pend_q | cpuPulse;
    assign effWr    = cpuPulse ? CPU_WR : pendWr_q;
    assign effData  = cpuPulse ? CPU_WDATA : pendData_q;
    assign renGo    = REN_REQ & ~BLNK;
    assign decide   = (state_q == IDLE) || (state_q == R_DAT) || (state_q == C_DAT);
    assign grant    = decide && (state_d == C_ALE);

`ifdef VRAM_SCHED_STARVE_GUARD_EN
    localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);
    logic [7:0] starve_q, starve_d;

    assign starveHit = (starve_q >= StarveLim);

    always_comb begin
        starve_d = starve_q;
        if (grant) begin
            starve_d = '0;
        end else if (pend_q && (starve_q < StarveLim)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starveHit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            R_ALE:   state_d = R_DAT;
            C_ALE:   state_d = C_DAT;
            default: begin
                if (effPend && starveHit) begin
                    state_d = C_ALE;
                end else if (renGo) begin
                    state_d = R_ALE;
                end else if (effPend) begin
                    state_d = C_ALE;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // The pending slot empties when its request is granted; a pulse in that same cycle supersedes it.
    always_comb begin
        pend_d     = pend_q;
        pendWr_d   = pendWr_q;
        pendData_d = pendData_q;
        curWr_d    = curWr_q;
        curData_d  = curData_q;
        addr_d     = addr_q;
        if (grant) begin
            pend_d    = 1'b0;
            curWr_d   = effWr;
            curData_d = effData;
        end else if (cpuPulse) begin
            pend_d     = 1'b1;
            pendWr_d   = CPU_WR;
            pendData_d = CPU_WDATA;
        end
        if (state_q == R_ALE) begin
            addr_d = REN_ADDR;
        end else if (state_q == C_ALE) begin
            addr_d = CPU_ADDR;
        end
        renVld_d  = (state_q == R_DAT);
        renData_d = (state_q == R_DAT) ? PD_IN : renData_q;
        rbLoad_d  = (state_q == C_DAT) && !curWr_q;
        rbData_d  = ((state_q == C_DAT) && !curWr_q) ? PD_IN : rbData_q;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pendWr_q   <= 1'b0;
            pendData_q <= '0;
            curWr_q    <= 1'b0;
            curData_q  <= '0;
            addr_q     <= '0;
            renVld_q   <= 1'b0;
            renData_q  <= '0;
            rbLoad_q   <= 1'b0;
            rbData_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pendWr_q   <= pendWr_d;
            pendData_q <= pendData_d;
            curWr_q    <= curWr_d;
            curData_q  <= curData_d;
            addr_q     <= addr_d;
            renVld_q   <= renVld_d;
            renData_q  <= renData_d;
            rbLoad_q   <= rbLoad_d;
            rbData_q   <= rbData_d;
        end
    end

    // Every output is forced low while reset is asserted so an abandoned access emits no strobes.
    always_comb begin
        REN_ACK  = 1'b0;
        REN_DATA = '0;
        REN_VLD  = 1'b0;
        CPU_BUSY = 1'b0;
        CPU_OVF  = 1'b0;
        PA_OUT   = '0;
        PD_OUT   = '0;
        PD_OE    = 1'b0;
        ALE      = 1'b0;
        RD       = 1'b0;
        WR       = 1'b0;
        RB_DATA  = '0;
        RB_LOAD  = 1'b0;
        TSTEP    = 1'b0;
        if (!RES) begin
            REN_ACK  = (state_q == R_ALE);
            REN_DATA = renData_q;
            REN_VLD  = renVld_q;
            CPU_BUSY = pend_q || (state_q == C_ALE) || (state_q == C_DAT);
            CPU_OVF  = cpuPulse && (pend_q || (CPU_RD && CPU_WR));
            ALE      = (state_q == R_ALE) || (state_q == C_ALE);
            if (state_q == R_ALE) begin
                PA_OUT = REN_ADDR;
            end else if (state_q == C_ALE) begin
                PA_OUT = CPU_ADDR;
            end else begin
                PA_OUT = addr_q;
            end
            if (((state_q == C_ALE) || (state_q == C_DAT)) && curWr_q) begin
                PD_OE  = 1'b1;
                PD_OUT = curData_q;
            end
            RD       = (state_q == R_DAT) || ((state_q == C_DAT) && !curWr_q);
            WR       = (state_q == C_DAT) && curWr_q;
            TSTEP    = (state_q == C_DAT);
            RB_DATA  = rbData_q;
            RB_LOAD  = rbLoad_q;
        end
    end

endmodule

// File: tb/tb_vram_bus_sched.sv
// Directed bench for vram_bus_sched: CPU read/write, reset abort, render streaming, overwrite and collision.
// Expectations for the render stream follow VRAM_SCHED_STARVE_GUARD_EN when it is defined (STARVE_LIMIT=4).
module tb_vram_bus_sched;

    logic        CLK, RES, BLNK, REN_REQ, REN_ACK, REN_VLD;
    logic [13:0] REN_ADDR, CPU_ADDR, PA_OUT;
    logic [7:0]  REN_DATA, CPU_WDATA, PD_IN, PD_OUT, RB_DATA;
    logic        CPU_RD, CPU_WR, CPU_BUSY, CPU_OVF, PD_OE, ALE, RD, WR, RB_LOAD, TSTEP;

    int total = 0;
    int bad   = 0;
    logic [13:0] renAddrs [0:3];

    vram_bus_sched #(.AW(14), .DW(8), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RES(RES), .BLNK(BLNK), .REN_REQ(REN_REQ), .REN_ADDR(REN_ADDR),
        .REN_ACK(REN_ACK), .REN_DATA(REN_DATA), .REN_VLD(REN_VLD),
        .CPU_RD(CPU_RD), .CPU_WR(CPU_WR), .CPU_WDATA(CPU_WDATA), .CPU_ADDR(CPU_ADDR),
        .CPU_BUSY(CPU_BUSY), .CPU_OVF(CPU_OVF), .PD_IN(PD_IN), .PA_OUT(PA_OUT),
        .PD_OUT(PD_OUT), .PD_OE(PD_OE), .ALE(ALE), .RD(RD), .WR(WR),
        .RB_DATA(RB_DATA), .RB_LOAD(RB_LOAD), .TSTEP(TSTEP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        BLNK = 1'b1; REN_REQ = 1'b0; REN_ADDR = '0; CPU_RD = 1'b0; CPU_WR = 1'b0;
        CPU_WDATA = '0; CPU_ADDR = '0; PD_IN = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        #1;
        if (ALE !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold_ale got=%0h want=0", ALE); end total++;
        if (CPU_BUSY !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold_busy got=%0h want=0", CPU_BUSY); end total++;
        @(negedge CLK); RES = 1'b0; #1;
        if (PA_OUT !== 14'h0) begin bad++; $display("[TB] FAIL rst_pa got=%0h want=0", PA_OUT); end total++;
        if (PD_OUT !== 8'h0) begin bad++; $display("[TB] FAIL rst_pd got=%0h want=0", PD_OUT); end total++;
        if ({PD_OE, ALE, RD, WR, TSTEP, RB_LOAD, REN_VLD, REN_ACK} !== 8'h0) begin
            bad++; $display("[TB] FAIL rst_strobes got=%0h want=0", {PD_OE, ALE, RD, WR, TSTEP, RB_LOAD, REN_VLD, REN_ACK});
        end total++;
        if ({REN_DATA, RB_DATA} !== 16'h0) begin bad++; $display("[TB] FAIL rst_data got=%0h want=0", {REN_DATA, RB_DATA}); end total++;
    endtask

    task automatic test_cpu_write();
        @(negedge CLK); CPU_WR = 1'b1; CPU_WDATA = 8'h5A; CPU_ADDR = 14'h2005; #1;
        if (CPU_OVF !== 1'b0) begin bad++; $display("[TB] FAIL wr_ovf got=%0h want=0", CPU_OVF); end total++;
        @(negedge CLK); CPU_WR = 1'b0; #1;
        if (ALE !== 1'b1) begin bad++; $display("[TB] FAIL wr_ale got=%0h want=1", ALE); end total++;
        if (PA_OUT !== 14'h2005) begin bad++; $display("[TB] FAIL wr_pa got=%0h want=2005", PA_OUT); end total++;
        if (PD_OE !== 1'b1) begin bad++; $display("[TB] FAIL wr_oe got=%0h want=1", PD_OE); end total++;
        if (PD_OUT !== 8'h5A) begin bad++; $display("[TB] FAIL wr_pd got=%0h want=5a", PD_OUT); end total++;
        if (CPU_BUSY !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy got=%0h want=1", CPU_BUSY); end total++;
        @(negedge CLK); CPU_ADDR = 14'h3FFF; #1;
        if ({ALE, WR, RD, TSTEP, PD_OE} !== 5'b01011) begin bad++; $display("[TB] FAIL wr_dat_strobes got=%b want=01011", {ALE, WR, RD, TSTEP, PD_OE}); end total++;
        if (PA_OUT !== 14'h2005) begin bad++; $display("[TB] FAIL wr_pa_hold got=%0h want=2005", PA_OUT); end total++;
        @(negedge CLK); #1;
        if ({ALE, WR, TSTEP, PD_OE, CPU_BUSY} !== 5'b0) begin bad++; $display("[TB] FAIL wr_idle got=%b want=00000", {ALE, WR, TSTEP, PD_OE, CPU_BUSY}); end total++;
    endtask

    task automatic test_cpu_read();
        int tsteps = 0;
        @(negedge CLK); CPU_RD = 1'b1; CPU_ADDR = 14'h1234; PD_IN = 8'hC3; #1;
        tsteps += int'(TSTEP);
        @(negedge CLK); CPU_RD = 1'b0; #1;
        tsteps += int'(TSTEP);
        if ({ALE, PD_OE} !== 2'b10) begin bad++; $display("[TB] FAIL rd_ale got=%b want=10", {ALE, PD_OE}); end total++;
        if (PA_OUT !== 14'h1234) begin bad++; $display("[TB] FAIL rd_pa got=%0h want=1234", PA_OUT); end total++;
        @(negedge CLK); #1;
        tsteps += int'(TSTEP);
        if ({RD, WR} !== 2'b10) begin bad++; $display("[TB] FAIL rd_strobe got=%b want=10", {RD, WR}); end total++;
        @(negedge CLK); #1;
        tsteps += int'(TSTEP);
        if (RB_LOAD !== 1'b1) begin bad++; $display("[TB] FAIL rd_load got=%0h want=1", RB_LOAD); end total++;
        if (RB_DATA !== 8'hC3) begin bad++; $display("[TB] FAIL rd_data got=%0h want=c3", RB_DATA); end total++;
        @(negedge CLK); #1;
        tsteps += int'(TSTEP);
        if (RB_LOAD !== 1'b0) begin bad++; $display("[TB] FAIL rd_load_end got=%0h want=0", RB_LOAD); end total++;
        if (tsteps != 1) begin bad++; $display("[TB] FAIL rd_tstep_count got=%0d want=1", tsteps); end total++;
    endtask

    task automatic test_reset_mid_read();
        @(negedge CLK); CPU_RD = 1'b1; CPU_ADDR = 14'h0ABC; PD_IN = 8'h77; #1;
        @(negedge CLK); CPU_RD = 1'b0; #1;
        @(negedge CLK); RES = 1'b1; #1;
        if ({TSTEP, RD} !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_strobes got=%b want=00", {TSTEP, RD}); end total++;
        @(negedge CLK); RES = 1'b0; #1;
        if ({RB_LOAD, TSTEP, ALE, RD, CPU_BUSY} !== 5'b0) begin bad++; $display("[TB] FAIL rstmid_after got=%b want=00000", {RB_LOAD, TSTEP, ALE, RD, CPU_BUSY}); end total++;
        if (RB_DATA !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_rbdata got=%0h want=0", RB_DATA); end total++;
        if (PA_OUT !== 14'h0) begin bad++; $display("[TB] FAIL rstmid_pa got=%0h want=0", PA_OUT); end total++;
    endtask

    task automatic test_render_stream();
        logic [11:0] expAle, expAck, expVld, expTstep, expLoad;
        int cpuAle, acksSeen, expIdx;
        acksSeen = 0;
        expIdx   = 0;
        expAle   = 12'h2AA;
`ifdef VRAM_SCHED_STARVE_GUARD_EN
        expAck = 12'h22A; expVld = 12'h8A8; expTstep = 12'h100; expLoad = 12'h200; cpuAle = 7;
`else
        expAck = 12'h0AA; expVld = 12'h2A8; expTstep = 12'h400; expLoad = 12'h800; cpuAle = 9;
`endif
        renAddrs[0] = 14'h2000; renAddrs[1] = 14'h23C0; renAddrs[2] = 14'h2001; renAddrs[3] = 14'h23C1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            BLNK = 1'b0;
            REN_REQ = (acksSeen < 4);
            if (acksSeen < 4) REN_ADDR = renAddrs[acksSeen];
            CPU_RD = (c == 1);
            CPU_ADDR = 14'h3F00;
            PD_IN = 8'h40 + c[7:0];
            #1;
            if (ALE !== expAle[c]) begin bad++; $display("[TB] FAIL ren_ale c=%0d got=%0h want=%0h", c, ALE, expAle[c]); end total++;
            if (REN_ACK !== expAck[c]) begin bad++; $display("[TB] FAIL ren_ack c=%0d got=%0h want=%0h", c, REN_ACK, expAck[c]); end total++;
            if (REN_VLD !== expVld[c]) begin bad++; $display("[TB] FAIL ren_vld c=%0d got=%0h want=%0h", c, REN_VLD, expVld[c]); end total++;
            if (TSTEP !== expTstep[c]) begin bad++; $display("[TB] FAIL ren_tstep c=%0d got=%0h want=%0h", c, TSTEP, expTstep[c]); end total++;
            if (RB_LOAD !== expLoad[c]) begin bad++; $display("[TB] FAIL ren_rbload c=%0d got=%0h want=%0h", c, RB_LOAD, expLoad[c]); end total++;
            if (expAck[c]) begin
                if (PA_OUT !== renAddrs[expIdx]) begin bad++; $display("[TB] FAIL ren_pa c=%0d got=%0h want=%0h", c, PA_OUT, renAddrs[expIdx]); end total++;
                expIdx++;
            end
            if (c == cpuAle) begin
                if (PA_OUT !== 14'h3F00) begin bad++; $display("[TB] FAIL ren_cpu_pa c=%0d got=%0h want=3f00", c, PA_OUT); end total++;
            end
            if (c >= 2 && c <= cpuAle) begin
                if (CPU_BUSY !== 1'b1) begin bad++; $display("[TB] FAIL ren_busy c=%0d got=%0h want=1", c, CPU_BUSY); end total++;
            end
            if (expVld[c]) begin
                if (REN_DATA !== 8'h3F + c[7:0]) begin bad++; $display("[TB] FAIL ren_data c=%0d got=%0h want=%0h", c, REN_DATA, 8'h3F + c[7:0]); end total++;
            end
            if (expLoad[c]) begin
                if (RB_DATA !== 8'h3F + c[7:0]) begin bad++; $display("[TB] FAIL ren_rbdata c=%0d got=%0h want=%0h", c, RB_DATA, 8'h3F + c[7:0]); end total++;
            end
            if (REN_ACK === 1'b1) acksSeen++;
        end
        idle_inputs();
    endtask

    task automatic test_overwrite();
        int ovfs = 0, tsteps = 0, loads = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            BLNK = 1'b0;
            REN_REQ = (c <= 5);
            REN_ADDR = 14'h2400 + c[13:0];
            CPU_RD = (c == 1) || (c == 3);
            CPU_ADDR = 14'h0555;
            PD_IN = 8'h90 + c[7:0];
            #1;
            ovfs += int'(CPU_OVF); tsteps += int'(TSTEP); loads += int'(RB_LOAD);
            if (c == 3) begin
                if (CPU_OVF !== 1'b1) begin bad++; $display("[TB] FAIL ovw_ovf got=%0h want=1", CPU_OVF); end total++;
            end
            if (c == 7) begin
                if ({ALE, REN_ACK} !== 2'b10 || PA_OUT !== 14'h0555) begin bad++; $display("[TB] FAIL ovw_cpu_ale got=%b/%0h want=10/555", {ALE, REN_ACK}, PA_OUT); end total++;
            end
            if (c == 9) begin
                if (RB_DATA !== 8'h98) begin bad++; $display("[TB] FAIL ovw_rbdata got=%0h want=98", RB_DATA); end total++;
            end
        end
        idle_inputs();
        if (ovfs != 1) begin bad++; $display("[TB] FAIL ovw_ovf_count got=%0d want=1", ovfs); end total++;
        if (tsteps != 1) begin bad++; $display("[TB] FAIL ovw_tstep_count got=%0d want=1", tsteps); end total++;
        if (loads != 1) begin bad++; $display("[TB] FAIL ovw_load_count got=%0d want=1", loads); end total++;
    endtask

    task automatic test_collision();
        @(negedge CLK);
        BLNK = 1'b1; REN_REQ = 1'b1; REN_ADDR = 14'h2222;
        CPU_RD = 1'b1; CPU_WR = 1'b1; CPU_WDATA = 8'hA5; CPU_ADDR = 14'h0100;
        #1;
        if (CPU_OVF !== 1'b1) begin bad++; $display("[TB] FAIL col_ovf got=%0h want=1", CPU_OVF); end total++;
        @(negedge CLK); CPU_RD = 1'b0; CPU_WR = 1'b0; #1;
        if ({ALE, REN_ACK, PD_OE} !== 3'b101) begin bad++; $display("[TB] FAIL col_ale got=%b want=101", {ALE, REN_ACK, PD_OE}); end total++;
        if (PD_OUT !== 8'hA5 || PA_OUT !== 14'h0100) begin bad++; $display("[TB] FAIL col_bus got=%0h/%0h want=a5/100", PD_OUT, PA_OUT); end total++;
        @(negedge CLK); #1;
        if ({WR, RD, TSTEP} !== 3'b101) begin bad++; $display("[TB] FAIL col_dat got=%b want=101", {WR, RD, TSTEP}); end total++;
        @(negedge CLK); #1;
        if ({RB_LOAD, WR, ALE, REN_ACK} !== 4'b0) begin bad++; $display("[TB] FAIL col_after got=%b want=0000", {RB_LOAD, WR, ALE, REN_ACK}); end total++;
        idle_inputs();
    endtask

    initial begin
        RES = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_reset_mid_read();
        test_render_stream();
        repeat (2) @(negedge CLK);
        test_overwrite();
        repeat (2) @(negedge CLK);
        test_collision();
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
